// File: rtl/jtag_pkg.sv
// Shared definitions for the OpenJTAG result path: flag positions, entry width, packer FSM states.
package jtag_pkg;

   localparam int unsigned JTAG_RES_FLUSH   = 0;
   localparam int unsigned JTAG_RES_MAXBITS = 8;

   typedef enum logic [0:0] {
      StIdle,
      StHold
   } jtag_pack_state_e;

   // Low `count` bits set; counts of 8 or more give all ones.
   function automatic logic [7:0] count_mask(input logic [3:0] count);
      logic [7:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < JTAG_RES_MAXBITS; i++) begin
         mask[i] = (4'(i) < count);
      end
      return mask;
   endfunction

endpackage

// File: rtl/jtag_byte_fifo.sv
// Synchronous FIFO accepting up to two writes and one read per cycle, with a free-slot count.
module jtag_byte_fifo #(
   parameter int unsigned OUT_DEPTH = 4,
   parameter int unsigned WIDTH     = 9
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [1:0]                     wr_num,
   input  logic [WIDTH-1:0]               wr_data0,
   input  logic [WIDTH-1:0]               wr_data1,
   input  logic                           rd_en,
   output logic [WIDTH-1:0]               rd_data,
   output logic                           rd_valid,
   output logic [$clog2(OUT_DEPTH):0]     free_count
);

   localparam int unsigned Aw = $clog2(OUT_DEPTH);

   logic [WIDTH-1:0] r_mem [OUT_DEPTH];
   logic [Aw-1:0]    r_wr_ptr;
   logic [Aw-1:0]    r_rd_ptr;
   logic [Aw:0]      r_count;
   logic [Aw-1:0]    w_wr_ptr1;
   logic             w_rd;

   assign w_wr_ptr1  = r_wr_ptr + Aw'(1);
   assign w_rd       = rd_en && (r_count != '0);
   assign rd_valid   = (r_count != '0);
   assign rd_data    = r_mem[r_rd_ptr];
   assign free_count = (Aw+1)'(OUT_DEPTH) - r_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (wr_num != 2'd0) r_mem[r_wr_ptr] <= wr_data0;
         if (wr_num == 2'd2) r_mem[w_wr_ptr1] <= wr_data1;
         r_wr_ptr <= r_wr_ptr + Aw'(wr_num);
         if (w_rd) r_rd_ptr <= r_rd_ptr + Aw'(1);
         r_count  <= r_count + (Aw+1)'(wr_num) - (Aw+1)'(w_rd);
      end
   end

endmodule

// File: rtl/jtag_tdo_packer.sv
// Packs variable-width TDO result entries LSB-first into bytes for the host endpoint buffer.
module jtag_tdo_packer
   import jtag_pkg::*;
#(
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       res_valid,
   input  logic [3:0] res_flags,
   input  logic [3:0] res_count,
   input  logic [7:0] res_bits,
   output logic       res_pop,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       err,
   input  logic       clear_err
);

   localparam int unsigned     OutAw   = $clog2(OUT_DEPTH);
   localparam logic [OutAw:0]  MinFree = (OutAw+1)'(2);

   jtag_pack_state_e r_state, w_state_next;
   logic             r_res_pop;
   logic             w_accept;
   logic             r_ent_flush;
   logic [3:0]       r_ent_count;
   logic [7:0]       r_ent_bits;
   logic [14:0]      r_acc, w_acc_next;
   logic [2:0]       r_fill, w_fill_next;
   logic             r_err, w_err_set;
   logic             w_merge, w_legal;
   logic [14:0]      w_m;
   logic [3:0]       w_n;
   logic [1:0]       w_wr_num;
   logic [8:0]       w_wr_data0, w_wr_data1;
   logic [OutAw:0]   w_free;
   logic [8:0]       w_rd_data;
   logic             w_unused;

   assign w_unused = ^res_flags[3:1];

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         StIdle: begin
            // Two free slots cover the worst case of a full byte plus a flushed partial.
            if (res_valid && (w_free >= MinFree)) begin
               w_accept     = 1'b1;
               w_state_next = StHold;
            end
         end
         StHold:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   assign w_merge = (r_state == StHold);
   assign w_legal = (r_ent_count != 4'd0) && (r_ent_count <= 4'(JTAG_RES_MAXBITS));

   always_comb begin
      w_wr_num    = 2'd0;
      w_wr_data0  = '0;
      w_wr_data1  = '0;
      w_acc_next  = r_acc;
      w_fill_next = r_fill;
      w_err_set   = 1'b0;
      w_m = r_acc | ({7'd0, r_ent_bits & count_mask(r_ent_count)} << r_fill);
      w_n = {1'b0, r_fill} + r_ent_count;
      if (w_merge) begin
         if (!w_legal) begin
            w_err_set = 1'b1;
         end else begin
            if (w_n >= 4'd8) begin
               w_wr_data0 = {1'b0, w_m[7:0]};
               w_wr_num   = 2'd1;
               w_m        = w_m >> 8;
               w_n        = w_n - 4'd8;
            end
            if (r_ent_flush && (w_n != 4'd0)) begin
               if (w_wr_num == 2'd0) w_wr_data0 = {1'b1, w_m[7:0]};
               else                  w_wr_data1 = {1'b1, w_m[7:0]};
               w_wr_num = w_wr_num + 2'd1;
               w_n      = 4'd0;
            end else if (r_ent_flush && (w_wr_num != 2'd0)) begin
               w_wr_data0[8] = 1'b1;
            end
            w_acc_next  = w_m & ((15'd1 << w_n) - 15'd1);
            w_fill_next = w_n[2:0];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_res_pop   <= 1'b0;
         r_ent_flush <= 1'b0;
         r_ent_count <= '0;
         r_ent_bits  <= '0;
         r_acc       <= '0;
         r_fill      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_res_pop <= w_accept;
         if (w_accept) begin
            r_ent_flush <= res_flags[JTAG_RES_FLUSH];
            r_ent_count <= res_count;
            r_ent_bits  <= res_bits;
         end
         r_acc  <= w_acc_next;
         r_fill <= w_fill_next;
         r_err  <= w_err_set | (r_err & ~clear_err);
      end
   end

   jtag_byte_fifo #(
      .OUT_DEPTH (OUT_DEPTH),
      .WIDTH     (9)
   ) u_out_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_num     (w_wr_num),
      .wr_data0   (w_wr_data0),
      .wr_data1   (w_wr_data1),
      .rd_en      (out_ready),
      .rd_data    (w_rd_data),
      .rd_valid   (out_valid),
      .free_count (w_free)
   );

   assign res_pop  = r_res_pop;
   assign out_data = w_rd_data[7:0];
   assign out_last = w_rd_data[8];
   assign err      = r_err;

endmodule

// File: doc/jtag_tdo_packer.md
# jtag_tdo_packer

Downstream consumer of the OpenJTAG block's result FIFOs. Pops one result entry per `dOutReq` assertion: a 4-bit flags nibble, a 4-bit valid-bit count, and up to 8 captured TDO bits. Concatenates the valid bits LSB-first into a continuous bit stream and emits whole bytes on a valid/ready byte interface toward the host (USB endpoint) buffer. A flush flag forces out a zero-padded partial byte that is marked `out_last`.

## Interface

**Parameters**
- `OUT_DEPTH`, 4: output byte FIFO depth; must be a power of two and ≥ 2.

**Ports**
- `clock` in 1: UDB clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `res_valid` in 1: result entry available (OpenJTAG `dOutReq`, level).
- `res_flags` in 4: bit0 = flush; bits 3:1 reserved, ignored.
- `res_count` in 4: number of valid bits in `res_bits`; legal range 1..8.
- `res_bits` in 8: captured TDO bits, first-shifted bit in bit0.
- `res_pop` out 1: one-cycle pulse that pops both result FIFOs.
- `out_data` out 8: packed byte, first bit in bit0.
- `out_valid` out 1: `out_data` / `out_last` valid.
- `out_ready` in 1: consumer accepts the byte when `out_valid && out_ready`.
- `out_last` out 1: byte ends a flushed sequence.
- `err` out 1: sticky illegal-count flag.
- `clear_err` in 1: synchronous clear of `err`.

## Operation

**State**
- `acc[14:0]`: bit accumulator.
- `fill[2:0]`: number of pending bits in `acc` (0..7).
- Output FIFO of {`last`, `data[7:0]`}.
- FSM with two states, IDLE and HOLD.

**IDLE**
- Accept an entry when `res_valid` is high and the FIFO has at least 2 free slots.
- On accept: pulse `res_pop` and go to HOLD.

**HOLD**
- Lasts exactly one cycle and ignores `res_valid`, because `dOutReq` lags the pop.
- Returns to IDLE.

**Merge on accept** (legal count)
- `m = acc | ((res_bits & mask(res_count)) << fill)`; `n = fill + res_count` (4-bit, max 15).
- If `n ≥ 8`: push `m[7:0]`; then `m >>= 8`, `n -= 8`.
- If flush is set and `n > 0`: push `m[7:0]` with `last=1`, then set `n = 0`.
- If flush is set and the final push was a full byte with `n == 0`: that full byte carries `last=1`.
- Flush with `n == 0` and no byte pushed in this merge: push nothing.
- `acc <= m`, masked to `n` bits; `fill <= n`.

**Illegal count** (`res_count` is 0 or greater than 8)
- The entry is still popped, with normal HOLD.
- `err` is set; `acc` and `fill` are unchanged; no byte is pushed.

**Other rules**
- `clear_err` and a new error in the same cycle: `err` stays 1 (set wins).
- Output FIFO push and pop in the same cycle are both honoured. Full and empty are never violated, given the 2-slot accept guard.

## Timing

**Reset values**
- `res_pop` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `err` = 0.
- `acc` = 0, `fill` = 0, FSM = IDLE, FIFO empty.

**Latency and throughput**
- `res_pop` is registered; it is high in the cycle after the accept decision.
- A pushed byte is visible on `out_valid` in the cycle after `res_pop`.
- Maximum throughput is one entry per 2 cycles.

**Handshake**
- `out_data` and `out_last` are held stable while `out_valid && !out_ready`.

**Reset mid-operation**
- Asserting `reset_n` low discards pending bits and FIFO contents immediately (asynchronous).
- The next entry after reset starts at bit position 0.

## Structure

- Shared package (`jtag_pkg`):
  - Flag bit index `JTAG_RES_FLUSH = 0`.
  - Maximum entry width `JTAG_RES_MAXBITS = 8`.
- Sub-module `jtag_byte_fifo`: a synchronous FIFO with `OUT_DEPTH` and 9-bit width, exposing a `free_count` output. It is reusable for the host-to-OpenJTAG command path.
- The FSM, merge logic, and error handling stay in the top module.

## Test plan

1. count=8, bits=0xA5, no flush → one byte 0xA5, `last=0`; `fill` returns to 0.
2. count=4, bits=0x09, then count=4, bits=0x0C → single byte 0xC9, `last=0`.
3. count=4, bits=0x09, flush → byte 0x09, `last=1`.
4. count=6, bits=0x3F, then count=5, bits=0x15, flush → byte 0x7F (`last=0`), then 0x05 (`last=1`).
5. Hold `out_ready=0` and feed four count=8 entries → only entries allowed while ≥ 2 slots are free are accepted, and `res_pop` stays low afterwards. Release `out_ready` → bytes emerge in order, and `res_pop` resumes.
6. Two illegal entries:
   - count=0 → `err=1`, one `res_pop`, no output byte.
   - count=9 → `err` stays 1.
   - Then `clear_err` → `err=0`.
   - Additionally, assert `reset_n` low with `fill=3` → all outputs are at reset values, and the next count=8 entry with bits=0x11 yields exactly 0x11.
